// File: rtl/pipe_array.sv
// pipe_array: scrolling pipe obstacles for a side-scroller.
// Pipes hold still for a few ticks after Start, then move left by Speed+1
// pixels per tick. A pipe that would pass X=0 respawns one full field width
// to the right with a fresh gap height. Crossing BIRD_X bumps a
// saturating score and pulses Passed for one cycle.
module pipe_array #(
   parameter int          NUM_PIPES  = 2,
   parameter int          XW         = 11,
   parameter int          TICK_DIV   = 500000,
   parameter int          START_X    = 800,
   parameter int          SPACING    = 400,
   parameter int          WAIT_TICKS = 512,
   parameter int          BIRD_X     = 200,
   parameter int          Y_MIN      = 20,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Start,
   input  logic                    Lost,
   input  logic [1:0]              Speed,
   output logic [NUM_PIPES*XW-1:0] PipePosX,
   output logic [NUM_PIPES*10-1:0] PipePosY,
   output logic                    Passed,
   output logic [7:0]              Score,
   output logic                    Active
);

   localparam int DW = $clog2(TICK_DIV);
   localparam int WW = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;

   localparam logic [XW-1:0] WRAP_X  = XW'(NUM_PIPES * SPACING);
   localparam logic [XW-1:0] BIRD_XV = XW'(BIRD_X);
   localparam logic [9:0]    Y_MINV  = 10'(Y_MIN);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_WAIT   = 4'b0010,
      S_RUN    = 4'b0100,
      S_FROZEN = 4'b1000
   } state_t;

   state_t          state_q;
   logic [DW-1:0]   div_q;
   logic [WW-1:0]   wait_q;
   logic [15:0]     lfsr_q;
   logic [15:0]     lfsr_d;
   logic [XW-1:0]   pipe_x_q [NUM_PIPES];
   logic [9:0]      pipe_y_q [NUM_PIPES];
   logic            passed_q;
   logic [7:0]      score_q;
   logic            active_q;

   logic            tick;
   logic [XW-1:0]   step;
   logic            pass_any;
   logic [XW-1:0]   move_x_d [NUM_PIPES];
   logic [9:0]      move_y_d [NUM_PIPES];
   logic [XW-1:0]   load_x   [NUM_PIPES];
   logic [9:0]      load_y   [NUM_PIPES];

   assign tick   = (div_q == DW'(TICK_DIV - 1));
   assign step   = XW'(Speed) + XW'(1);
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Per-pipe load values and output packing.
   for (genvar k = 0; k < NUM_PIPES; k++) begin : g_pipe
      assign load_x[k] = XW'(START_X + k * SPACING);
      assign load_y[k] = Y_MINV + {2'b00, lfsr_q[7:0] ^ 8'(k * 8'h5A)};
      assign PipePosX[k*XW +: XW] = pipe_x_q[k];
      assign PipePosY[k*10 +: 10] = pipe_y_q[k];
   end

   // Candidate positions for the next tick: move left, or respawn one field
   // width to the right so spacing between pipes is kept exact.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path can
      // leave it unassigned and infer a latch.
      pass_any = 1'b0;
      move_x_d = pipe_x_q;
      move_y_d = pipe_y_q;
      for (int k = 0; k < NUM_PIPES; k++) begin
         if (pipe_x_q[k] < step) begin
            move_x_d[k] = pipe_x_q[k] + WRAP_X - step;
            move_y_d[k] = Y_MINV + {2'b00, lfsr_q[7:0]};
         end else begin
            move_x_d[k] = pipe_x_q[k] - step;
            if (pipe_x_q[k] >= BIRD_XV && move_x_d[k] < BIRD_XV) begin
               pass_any = 1'b1;
            end
         end
      end
   end

   // Game FSM with all state, counters, pipes and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         wait_q   <= '0;
         lfsr_q   <= SEED;
         passed_q <= 1'b0;
         score_q  <= 8'd0;
         active_q <= 1'b0;
         // NOTE: the pipe arrays are a handful of flops, not a RAM, so they
         // are reset like any other register.
         for (int k = 0; k < NUM_PIPES; k++) begin
            pipe_x_q[k] <= '1;
            pipe_y_q[k] <= Y_MINV;
         end
      end else begin
         // NOTE: non-blocking assignments so every register updates from
         // the same pre-edge values regardless of statement order.
         lfsr_q   <= lfsr_d;
         passed_q <= 1'b0;
         case (state_q)
            S_IDLE, S_FROZEN: begin
               div_q <= '0;
               if (Start && !Lost) begin
                  state_q <= S_WAIT;
                  wait_q  <= '0;
                  score_q <= 8'd0;
                  for (int k = 0; k < NUM_PIPES; k++) begin
                     pipe_x_q[k] <= load_x[k];
                     pipe_y_q[k] <= load_y[k];
                  end
               end
            end
            S_WAIT: begin
               if (Lost) begin
                  state_q <= S_FROZEN;
                  div_q   <= '0;
               end else begin
                  div_q <= tick ? '0 : div_q + DW'(1);
                  if (tick) begin
                     if (wait_q == WW'(WAIT_TICKS - 1)) begin
                        state_q  <= S_RUN;
                        active_q <= 1'b1;
                     end else begin
                        wait_q <= wait_q + WW'(1);
                     end
                  end
               end
            end
            S_RUN: begin
               if (Lost) begin
                  state_q  <= S_FROZEN;
                  active_q <= 1'b0;
                  div_q    <= '0;
               end else begin
                  div_q <= tick ? '0 : div_q + DW'(1);
                  if (tick) begin
                     pipe_x_q <= move_x_d;
                     pipe_y_q <= move_y_d;
                     if (pass_any) begin
                        passed_q <= 1'b1;
                        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                     end
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign Passed = passed_q;
   assign Score  = score_q;
   assign Active = active_q;

endmodule

// File: tb/tb_pipe_array.sv
// Directed bench for pipe_array: a per-tick vector table plus hand-written
// sequences for load timing, respawn, pass, freeze, reset and saturation.
module tb_pipe_array;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Lost;
   logic [1:0]  Speed;
   logic [21:0] x_bus;
   logic [19:0] y_bus;
   logic        passed;
   logic [7:0]  score;
   logic        active;

   // Second instance: one short-field pipe that passes often, for saturation.
   logic        start2;
   logic        lost2;
   logic [1:0]  speed2;
   logic [10:0] sat_x;
   logic [9:0]  sat_y;
   logic        sat_passed;
   logic [7:0]  sat_score;
   logic        sat_active;

   int n_checks = 0;
   int n_pass   = 0;
   int sat_pulses = 0;

   logic [15:0] lfsr_m;
   logic [7:0]  snap;
   int          y0_exp;
   int          y1_exp;

   pipe_array #(.TICK_DIV(4), .WAIT_TICKS(2)) u_dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Lost(Lost), .Speed(Speed),
      .PipePosX(x_bus), .PipePosY(y_bus), .Passed(passed), .Score(score),
      .Active(active)
   );

   pipe_array #(.NUM_PIPES(1), .TICK_DIV(2), .START_X(16), .SPACING(16),
                .WAIT_TICKS(1), .BIRD_X(8)) u_sat (
      .Clk(Clk), .Reset(Reset), .Start(start2), .Lost(lost2), .Speed(speed2),
      .PipePosX(sat_x), .PipePosY(sat_y), .Passed(sat_passed), .Score(sat_score),
      .Active(sat_active)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
   always @(posedge Clk) begin
      if (Reset) lfsr_m <= 16'hACE1;
      else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   always @(negedge Clk) if (sat_passed) sat_pulses++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Called #1 after a move edge; returns #1 after the next move edge.
   // Speed/Start are set to the "mid" values for the non-tick edges, then the
   // tick speed is applied for the two edges ending on the tick.
   task automatic do_tick(input logic [1:0] sp_mid, input logic [1:0] sp_tick,
                          input logic st_mid, input int skip);
      Speed = sp_mid;
      Start = st_mid;
      repeat (2 - skip) @(posedge Clk);
      #1 Speed = sp_tick;
      Start = 1'b0;
      @(posedge Clk);
      #1 snap = lfsr_m[7:0];
      @(posedge Clk);
      #1;
   endtask

   typedef struct {
      logic [1:0] sp_mid;
      logic [1:0] sp_tick;
      logic       st_mid;
      int         x0;
      int         x1;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{2'd3, 2'd1, 1'b1, 797, 1197};
      vecs[1] = '{2'd0, 2'd2, 1'b0, 794, 1194};
      vecs[2] = '{2'd2, 2'd0, 1'b1, 793, 1193};
      vecs[3] = '{2'd1, 2'd3, 1'b0, 789, 1189};
      vecs[4] = '{2'd3, 2'd1, 1'b0, 787, 1187};
      vecs[5] = '{2'd2, 2'd0, 1'b1, 786, 1186};

      Reset = 1'b1; Start = 1'b0; Lost = 1'b0; Speed = 2'd0;
      start2 = 1'b0; lost2 = 1'b0; speed2 = 2'd3;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_x0", x_bus[10:0], 2047);
      check("rst_x1", x_bus[21:11], 2047);
      check("rst_y0", y_bus[9:0], 20);
      check("rst_y1", y_bus[19:10], 20);
      check("rst_score", score, 0);
      check("rst_passed", passed, 0);
      check("rst_active", active, 0);
      Reset = 1'b0;

      // Lost beats Start in IDLE.
      Start = 1'b1; Lost = 1'b1;
      @(posedge Clk); #1;
      check("idle_lost_x0", x_bus[10:0], 2047);

      // Load.
      Lost = 1'b0;
      snap = lfsr_m[7:0];
      @(posedge Clk); #1;
      Start = 1'b0;
      y0_exp = 20 + snap;
      y1_exp = 20 + (snap ^ 8'h5A);
      check("load_x0", x_bus[10:0], 800);
      check("load_x1", x_bus[21:11], 1200);
      check("load_y0", y_bus[9:0], y0_exp);
      check("load_y1", y_bus[19:10], y1_exp);
      check("load_active", active, 0);

      // Active rises exactly 8 cycles after WAIT entry.
      repeat (7) @(posedge Clk); #1;
      check("wait_active_early", active, 0);
      @(posedge Clk); #1;
      check("run_active", active, 1);
      check("run_x0_held", x_bus[10:0], 800);

      // First move 4 cycles later at Speed=0.
      Speed = 2'd0;
      repeat (3) @(posedge Clk); #1;
      check("no_early_move", x_bus[10:0], 800);
      @(posedge Clk); #1;
      check("move1_x0", x_bus[10:0], 799);
      check("move1_x1", x_bus[21:11], 1199);

      // Speed changes between ticks, Start pulses in RUN ignored.
      for (int i = 0; i < 6; i++) begin
         do_tick(vecs[i].sp_mid, vecs[i].sp_tick, vecs[i].st_mid, 0);
         check($sformatf("vec%0d_x0", i), x_bus[10:0], vecs[i].x0);
         check($sformatf("vec%0d_x1", i), x_bus[21:11], vecs[i].x1);
         check($sformatf("vec%0d_passed", i), passed, 0);
      end

      // Run pipe 0 down to X=202 at step 4.
      for (int i = 0; i < 146; i++) do_tick(2'd3, 2'd3, 1'b0, 0);
      check("pre_pass_x0", x_bus[10:0], 202);
      check("pre_pass_x1", x_bus[21:11], 602);
      check("pre_pass_score", score, 0);

      // 202 -> 198 crosses BIRD_X.
      do_tick(2'd3, 2'd3, 1'b0, 0);
      check("pass_x0", x_bus[10:0], 198);
      check("pass_pulse", passed, 1);
      check("pass_score", score, 1);
      @(posedge Clk); #1;
      check("pass_pulse_end", passed, 0);
      do_tick(2'd3, 2'd3, 1'b0, 1);
      check("post_pass_x0", x_bus[10:0], 194);
      check("post_pass_passed", passed, 0);

      // Down to X=2, then respawn at step 4.
      for (int i = 0; i < 48; i++) do_tick(2'd3, 2'd3, 1'b0, 0);
      check("pre_respawn_x0", x_bus[10:0], 2);
      check("pre_respawn_x1", x_bus[21:11], 402);
      do_tick(2'd3, 2'd3, 1'b0, 0);
      y0_exp = 20 + snap;
      check("respawn_x0", x_bus[10:0], 798);
      check("respawn_y0", y_bus[9:0], y0_exp);
      check("respawn_x1", x_bus[21:11], 398);
      check("respawn_y1", y_bus[19:10], y1_exp);
      check("respawn_passed", passed, 0);
      check("respawn_score", score, 1);

      // Lost+Start on a tick cycle in RUN: freeze, move suppressed.
      Speed = 2'd0;
      repeat (3) @(posedge Clk);
      #1 Lost = 1'b1; Start = 1'b1;
      @(posedge Clk); #1;
      check("frz_x0", x_bus[10:0], 798);
      check("frz_x1", x_bus[21:11], 398);
      check("frz_active", active, 0);
      repeat (100) @(posedge Clk); #1;
      check("frz100_x0", x_bus[10:0], 798);
      check("frz100_x1", x_bus[21:11], 398);
      check("frz100_y0", y_bus[9:0], y0_exp);
      check("frz100_score", score, 1);

      // Start alone reloads.
      Lost = 1'b0;
      snap = lfsr_m[7:0];
      @(posedge Clk); #1;
      Start = 1'b0;
      check("reload_x0", x_bus[10:0], 800);
      check("reload_x1", x_bus[21:11], 1200);
      check("reload_y1", y_bus[19:10], 20 + (snap ^ 8'h5A));
      check("reload_score", score, 0);
      check("reload_active", active, 0);
      repeat (8) @(posedge Clk); #1;
      check("rerun_active", active, 1);

      // Reset on a tick cycle mid-RUN.
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk); #1;
      check("midrst_x0", x_bus[10:0], 2047);
      check("midrst_x1", x_bus[21:11], 2047);
      check("midrst_y0", y_bus[9:0], 20);
      check("midrst_active", active, 0);
      check("midrst_passed", passed, 0);
      Reset = 1'b0;

      // Lost in WAIT freezes before RUN is reached.
      Start = 1'b1;
      snap = lfsr_m[7:0];
      @(posedge Clk); #1;
      Start = 1'b0;
      check("load2_y0", y_bus[9:0], 20 + snap);
      repeat (2) @(posedge Clk);
      #1 Lost = 1'b1;
      @(posedge Clk);
      #1 Lost = 1'b0;
      repeat (12) @(posedge Clk); #1;
      check("wait_lost_active", active, 0);
      check("wait_lost_x0", x_bus[10:0], 800);

      // Score saturation on the short-field instance.
      start2 = 1'b1;
      @(posedge Clk);
      #1 start2 = 1'b0;
      repeat (3000) @(posedge Clk); #1;
      check("sat_score", sat_score, 255);
      check("sat_pulses_ge_256", (sat_pulses >= 256), 1);
      check("sat_active", sat_active, 1);
      check("sat_x_range", (sat_x <= 11'd16), 1);
      check("sat_y_range", (sat_y >= 10'd20), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
